// File: rtl/imem_loader.sv
// imem_loader
// Program loader and run supervisor that sits in front of SingleCycleCPU.
// It receives a byte stream, packs it into little-endian 32-bit words,
// writes those words into instruction memory, and then releases the CPU
// from reset. While the CPU runs it counts cycles until the CPU raises halt.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle load request; only looked at in IDLE and DONE
//   word_count   number of words to load; captured when start is accepted
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     loader can take a byte (high only in LOAD)
//   mem_we       instruction-memory write strobe, one cycle per word
//   mem_addr     byte address of the write
//   mem_wdata    write data
//   cpu_rst      active-low CPU reset; 0 holds the CPU in reset
//   halt         CPU halt flag
//   busy         high in LOAD, WRITE and RUN
//   done         high in DONE
//   cycles       RUN cycles that sampled halt low (saturating)
//   dbg_state    current FSM state encoding, for observation only
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is a register derived from the state, so
// it never depends combinationally on in_valid.
module imem_loader #(
    parameter int          AW        = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] word_count,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst,
    input  logic          halt,
    output logic          busy,
    output logic          done,
    output logic [31:0]   cycles,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] count_q;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic          accept;
    logic          start_ok;
    logic          last_word;
    logic [AW:0]   idx_p1;
    logic [31:0]   idx32;

    assign accept    = in_ready && in_valid;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    // One bit wider so word_count at its maximum value cannot wrap.
    assign idx_p1    = {1'b0, word_idx} + {{AW{1'b0}}, 1'b1};
    assign last_word = (idx_p1 == {1'b0, count_q});
    assign idx32     = 32'(word_idx);
    assign dbg_state = state;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = (word_count != '0) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                if (accept && (byte_idx == 2'd3)) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nx = last_word ? S_RUN : S_LOAD;
            end
            S_RUN: begin
                if (halt) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register plus registered outputs. The flag outputs are decoded
    // from the next state so they are glitch-free and line up exactly with
    // the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            cpu_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            cycles    <= 32'h0;
            count_q   <= '0;
            word_idx  <= '0;
            byte_idx  <= 2'd0;
            word_buf  <= 24'h0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == S_LOAD);
            mem_we   <= (state_nx == S_WRITE);
            cpu_rst  <= (state_nx == S_RUN) || (state_nx == S_DONE);
            busy     <= (state_nx == S_LOAD) || (state_nx == S_WRITE) ||
                        (state_nx == S_RUN);
            done     <= (state_nx == S_DONE);

            if (start_ok) begin
                count_q  <= word_count;
                cycles   <= 32'h0;
                byte_idx <= 2'd0;
                word_idx <= '0;
            end

            if (accept) begin
                if (byte_idx == 2'd3) begin
                    // The last byte goes straight into the write data so the
                    // word is ready during the WRITE cycle that follows.
                    mem_wdata <= {in_data, word_buf};
                    mem_addr  <= BASE_ADDR + {idx32[29:0], 2'b00};
                    byte_idx  <= 2'd0;
                end else begin
                    case (byte_idx)
                        2'd0:    word_buf[7:0]   <= in_data;
                        2'd1:    word_buf[15:8]  <= in_data;
                        default: word_buf[23:16] <= in_data;
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                end
            end

            if (state == S_WRITE) begin
                word_idx <= word_idx + {{(AW-1){1'b0}}, 1'b1};
            end

            if ((state == S_RUN) && !halt && (cycles != 32'hFFFF_FFFF)) begin
                cycles <= cycles + 32'h1;
            end
        end
    end

endmodule
